// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - decode stage: immediate pre-decode behind a 2-entry skid buffer
//
// Ports:
//   clk, rst          - clock; synchronous active-high reset
//   in_valid/in_ready - fetch-side handshake; in_ready = !skid_full (register driven)
//   instr_in, pc_in   - fetched instruction word and its PC
//   flush             - drop every held and incoming word (branch redirect)
//   out_valid/out_ready - execute-side handshake
//   instr_out, pc_out - registered instruction and PC (NOP_INSTR / 0 while idle)
//   imm_in_out        - packed immediate field for the extender
//   imm_ext_en_out    - extender mode: 00 s12, 01 s20, 10 u12, 11 u20
//   imm_shl1          - extended immediate is shifted left by one
//   has_imm           - instruction carries an immediate
//   illegal           - opcode not recognised (word still flows through)
module instr_decode_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [19:0] imm_in_out,
    output logic [1:0]  imm_ext_en_out,
    output logic        imm_shl1,
    output logic        has_imm,
    output logic        illegal
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [19:0] imm;
        logic [1:0]  en;
        logic        shl1;
        logic        has_imm;
        logic        illegal;
    } entry_t;

    // Idle value of an entry; main is reloaded with this whenever it empties so
    // the outputs come straight from flops and read as a NOP while invalid.
    localparam entry_t EMPTY_ENTRY = {NOP_INSTR, 57'd0};

    entry_t dec;
    entry_t main_q;
    entry_t skid_q;
    logic   main_valid;
    logic   skid_valid;
    logic   accept;
    logic   consume;

    always_comb begin
        dec         = EMPTY_ENTRY;
        dec.instr   = instr_in;
        dec.pc      = pc_in;
        dec.imm     = 20'd0;
        dec.en      = 2'b00;
        dec.shl1    = 1'b0;
        dec.has_imm = 1'b0;
        dec.illegal = 1'b0;
        case (instr_in[6:0])
            OP_LOAD, OP_JALR, OP_SYSTEM: begin
                dec.imm     = {8'd0, instr_in[31:20]};
                dec.has_imm = 1'b1;
            end
            OP_IMM: begin
                dec.has_imm = 1'b1;
                if (instr_in[14:12] == 3'b001 || instr_in[14:12] == 3'b101) begin
                    // shift amount only; upper imm bits carry funct7, not value
                    dec.imm = {15'd0, instr_in[24:20]};
                    dec.en  = 2'b10;
                end else begin
                    dec.imm = {8'd0, instr_in[31:20]};
                end
            end
            OP_STORE: begin
                dec.imm     = {8'd0, instr_in[31:25], instr_in[11:7]};
                dec.has_imm = 1'b1;
            end
            OP_BRANCH: begin
                dec.imm     = {8'd0, instr_in[31], instr_in[7], instr_in[30:25], instr_in[11:8]};
                dec.shl1    = 1'b1;
                dec.has_imm = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                dec.imm     = instr_in[31:12];
                dec.en      = 2'b11;
                dec.has_imm = 1'b1;
            end
            OP_JAL: begin
                dec.imm     = {instr_in[31], instr_in[19:12], instr_in[20], instr_in[30:21]};
                dec.en      = 2'b01;
                dec.shl1    = 1'b1;
                dec.has_imm = 1'b1;
            end
            OP_OP: begin
                dec.has_imm = 1'b0;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

    assign in_ready = ~skid_valid;
    assign accept   = in_valid && in_ready;
    assign consume  = main_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_valid <= 1'b0;
            main_q     <= EMPTY_ENTRY;
            skid_valid <= 1'b0;
            skid_q     <= EMPTY_ENTRY;
        end else if (!main_valid || consume) begin
            // skid is always older than any new word; in_ready is low while it
            // is full, so accept and skid_valid never coincide here
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_q     <= dec;
                main_valid <= 1'b1;
            end else begin
                main_q     <= EMPTY_ENTRY;
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid      = main_valid;
    assign instr_out      = main_q.instr;
    assign pc_out         = main_q.pc;
    assign imm_in_out     = main_q.imm;
    assign imm_ext_en_out = main_q.en;
    assign imm_shl1       = main_q.shl1;
    assign has_imm        = main_q.has_imm;
    assign illegal        = main_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - self-checking bench for instr_decode_stage
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [19:0] imm_in_out;
    logic [1:0]  imm_ext_en_out;
    logic        imm_shl1;
    logic        has_imm;
    logic        illegal;

    always #5 clk = ~clk;

    instr_decode_stage dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .instr_in       (instr_in),
        .pc_in          (pc_in),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .imm_in_out     (imm_in_out),
        .imm_ext_en_out (imm_ext_en_out),
        .imm_shl1       (imm_shl1),
        .has_imm        (has_imm),
        .illegal        (illegal)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [19:0] imm;
        logic [1:0]  en;
        logic        shl1;
        logic        has;
        logic        ill;
    } vec_t;

    localparam vec_t IDLE = {32'h0000_0013, 57'd0};

    int   checks = 0;
    int   passes = 0;
    vec_t sb[$];
    vec_t cur_exp;
    vec_t vec[12];
    vec_t bundle;
    vec_t prev_bundle;
    bit   held_prev = 1'b0;

    assign bundle = {instr_out, pc_out, imm_in_out, imm_ext_en_out, imm_shl1, has_imm, illegal};

    task automatic chk(input string name, input logic [88:0] act, input logic [88:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [31:0] i, input logic [19:0] imm, input logic [1:0] en,
                                input logic s, input logic h, input logic il);
        mk = {i, 32'h0, imm, en, s, h, il};
    endfunction

    // Scoreboard: accepted words pushed, consumed words popped and compared.
    always @(negedge clk) begin
        if (rst || flush) begin
            sb.delete();
            held_prev = 1'b0;
        end else begin
            if (held_prev) chk("hold_stable", bundle, prev_bundle);
            if (out_valid) begin
                if (out_ready) begin
                    if (sb.size() == 0) chk("unexpected_out", 89'd1, 89'd0);
                    else chk("out_word", bundle, sb.pop_front());
                end
            end else begin
                chk("idle_outputs", bundle, IDLE);
            end
            held_prev   = out_valid && !out_ready;
            prev_bundle = bundle;
            if (in_valid && in_ready) sb.push_back(cur_exp);
        end
    end

    task automatic send(input vec_t e, input bit rand_bp);
        bit done = 1'b0;
        in_valid = 1'b1;
        instr_in = e.instr;
        pc_in    = e.pc;
        cur_exp  = e;
        for (int n = 0; n < 200 && !done; n++) begin
            if (rand_bp) out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 89'd0, 89'd1);
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int n = 0; n < 100 && (sb.size() != 0 || out_valid); n++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", 89'(sb.size() == 0 && !out_valid), 89'd1);
    endtask

    initial begin
        vec_t e;
        vec_t a;
        vec_t b;
        vec[0]  = mk(32'hFFF00513, 20'h00FFF, 2'b00, 1'b0, 1'b1, 1'b0); // addi a0,x0,-1
        vec[1]  = mk(32'h123452B7, 20'h12345, 2'b11, 1'b0, 1'b1, 1'b0); // lui
        vec[2]  = mk(32'hFE000EE3, 20'h00FFE, 2'b00, 1'b1, 1'b1, 1'b0); // beq -4
        vec[3]  = mk(32'h0000007F, 20'h00000, 2'b00, 1'b0, 1'b0, 1'b1); // illegal
        vec[4]  = mk(32'h00B50533, 20'h00000, 2'b00, 1'b0, 1'b0, 1'b0); // add
        vec[5]  = mk(32'h00351513, 20'h00003, 2'b10, 1'b0, 1'b1, 1'b0); // slli 3
        vec[6]  = mk(32'h40355513, 20'h00003, 2'b10, 1'b0, 1'b1, 1'b0); // srai 3
        vec[7]  = mk(32'hFEB52C23, 20'h00FF8, 2'b00, 1'b0, 1'b1, 1'b0); // sw -8
        vec[8]  = mk(32'hFFDFF06F, 20'hFFFFE, 2'b01, 1'b1, 1'b1, 1'b0); // jal -4
        vec[9]  = mk(32'h00001097, 20'h00001, 2'b11, 1'b0, 1'b1, 1'b0); // auipc
        vec[10] = mk(32'h01012503, 20'h00010, 2'b00, 1'b0, 1'b1, 1'b0); // lw 16
        vec[11] = mk(32'h00008067, 20'h00000, 2'b00, 1'b0, 1'b1, 1'b0); // jalr ret

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        instr_in = 32'h0; pc_in = 32'h0; cur_exp = IDLE;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_out_valid", 89'(out_valid), 89'd0);
        chk("reset_in_ready", 89'(in_ready), 89'd1);
        chk("reset_outputs", bundle, IDLE);

        // single words, one-cycle latency
        for (int i = 0; i < 4; i++) begin
            e = vec[i];
            e.pc = 32'h100 + 32'(i * 4);
            out_ready = 1'b1;
            send(e, 1'b0);
            chk("latency_valid", 89'(out_valid), 89'd1);
            chk("latency_word", bundle, e);
            idle(1);
        end

        // table under random backpressure and gaps
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 12; i++) begin
                e = vec[i];
                e.pc = $urandom;
                send(e, 1'b1);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end
        drain();

        // fill both entries, then release
        a = vec[4]; a.pc = 32'h200;
        b = vec[5]; b.pc = 32'h204;
        out_ready = 1'b0;
        send(a, 1'b0);
        send(b, 1'b0);
        chk("skid_full_in_ready", 89'(in_ready), 89'd0);
        chk("skid_full_out_valid", 89'(out_valid), 89'd1);
        chk("skid_full_head", bundle, a);
        out_ready = 1'b1;
        idle(1);
        chk("skid_move_word", bundle, b);
        chk("skid_move_valid", 89'(out_valid), 89'd1);
        chk("skid_move_in_ready", 89'(in_ready), 89'd1);
        idle(1);
        chk("skid_drained", 89'(out_valid), 89'd0);

        // flush with both entries full and an incoming word
        out_ready = 1'b0;
        send(a, 1'b0);
        send(b, 1'b0);
        e = vec[6]; e.pc = 32'h300;
        in_valid = 1'b1; instr_in = e.instr; pc_in = e.pc; cur_exp = e;
        flush = 1'b1;
        idle(1);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 89'(out_valid), 89'd0);
        chk("flush_in_ready", 89'(in_ready), 89'd1);
        chk("flush_instr_out", 89'(instr_out), 89'h13);
        chk("flush_outputs", bundle, IDLE);
        out_ready = 1'b1;
        idle(2);
        chk("flush_no_leak", 89'(out_valid), 89'd0);

        // reset while a word is held and another is in flight
        out_ready = 1'b0;
        send(a, 1'b0);
        e = vec[7]; e.pc = 32'h400;
        in_valid = 1'b1; instr_in = e.instr; pc_in = e.pc; cur_exp = e;
        rst = 1'b1;
        idle(1);
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_out_valid", 89'(out_valid), 89'd0);
        chk("rst_in_ready", 89'(in_ready), 89'd1);
        chk("rst_outputs", bundle, IDLE);
        out_ready = 1'b1;
        idle(2);
        chk("rst_no_leak", 89'(out_valid), 89'd0);
        chk("sb_empty", 89'(sb.size()), 89'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 The module SHALL have parameter NOP_INSTR, default 32'h0000_0013, which is the instruction word driven on instr_out while out_valid is 0.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port in_valid, input, 1 bit: the fetch word on instr_in/pc_in is valid.
REQ-005 The module SHALL have port in_ready, output, 1 bit: the stage can accept a word this cycle.
REQ-006 The module SHALL have port instr_in, input, 32 bits, and port pc_in, input, 32 bits: the fetched instruction and its PC.
REQ-007 The module SHALL have port flush, input, 1 bit: discard every held and incoming word (branch redirect).
REQ-008 The module SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: downstream handshake.
REQ-009 The module SHALL have ports instr_out, output, 32 bits, and pc_out, output, 32 bits: the registered instruction and PC.
REQ-010 The module SHALL have port imm_in_out, output, 20 bits: the packed immediate field for the immediate extender.
REQ-011 The module SHALL have port imm_ext_en_out, output, 2 bits: the extender mode (00 = signed 12-bit, 01 = signed 20-bit, 10 = unsigned 12-bit, 11 = unsigned 20-bit).
REQ-012 The module SHALL have ports imm_shl1, output, 1 bit, and has_imm, output, 1 bit: the extended immediate must be shifted left by 1; the instruction uses an immediate.
REQ-013 The module SHALL have port illegal, output, 1 bit: the opcode is unrecognised.

Function
REQ-014 Decode SHALL be combinational on instr_in, with results captured together with instr_in/pc_in on acceptance; all outputs SHALL be registered, giving a latency of 1 cycle from acceptance to out_valid.
REQ-015 Decode SHALL use opcode instr[6:0] and SHALL drive imm bits [19:12] to 0 for every 12-bit mode.
REQ-016 LOAD 0000011, JALR 1100111, SYSTEM 1110011, and OP-IMM 0010011 with funct3 other than 001/101 SHALL decode as: imm = instr[31:20], en = 00, has_imm = 1.
REQ-017 OP-IMM with funct3 001 or 101 (shifts) SHALL decode as: imm[11:0] = {7'b0, instr[24:20]}, en = 10, has_imm = 1.
REQ-018 STORE 0100011 SHALL decode as: imm[11:0] = {instr[31:25], instr[11:7]}, en = 00, has_imm = 1.
REQ-019 BRANCH 1100011 SHALL decode as: imm[11:0] = {instr[31], instr[7], instr[30:25], instr[11:8]}, en = 00, imm_shl1 = 1, has_imm = 1.
REQ-020 LUI 0110111 and AUIPC 0010111 SHALL decode as: imm = instr[31:12], en = 11, has_imm = 1.
REQ-021 JAL 1101111 SHALL decode as: imm = {instr[31], instr[19:12], instr[20], instr[30:21]}, en = 01, imm_shl1 = 1, has_imm = 1.
REQ-022 OP 0110011 SHALL decode as: imm = 0, en = 00, has_imm = 0, illegal = 0.
REQ-023 Any other opcode SHALL decode as: imm = 0, en = 00, has_imm = 0, illegal = 1; the word SHALL still pass through the stage.
REQ-024 Buffering SHALL be a 2-entry skid buffer (main + skid), with in_ready driven directly from a register as !skid_full.
REQ-025 A word SHALL be accepted when in_valid && in_ready; it SHALL be consumed when out_valid && out_ready.
REQ-026 When main is empty, or is consumed in the same cycle, the accepted word SHALL go to main; if main is held (out_valid && !out_ready), the accepted word SHALL go to skid.
REQ-027 When skid is full and main is consumed, skid SHALL move to main and skid SHALL empty; in_ready SHALL be 0 while skid is full.
REQ-028 Data ordering SHALL be strict FIFO, and no word SHALL be duplicated or dropped except on flush.
REQ-029 While out_valid = 1 and out_ready = 0, all outputs SHALL hold stable.
REQ-030 On flush = 1, both entries SHALL be emptied at the next edge and any same-cycle input SHALL be discarded; flush SHALL have priority over accept and consume.
REQ-031 While out_valid = 0, instr_out SHALL be NOP_INSTR, pc_out SHALL be 0, imm_in_out SHALL be 0, imm_ext_en_out SHALL be 00, and imm_shl1, has_imm and illegal SHALL be 0.

Reset
REQ-032 While rst = 1 at a clock edge, both entries SHALL be emptied, giving out_valid = 0, outputs per REQ-031, and in_ready = 1 in the cycle after reset.
REQ-033 Reset SHALL have priority over flush, accept and consume; a word in flight during reset SHALL be lost.

Verification
REQ-034 The bench SHALL check that instr_in = 32'hFFF00513 (addi a0, x0, -1) accepted with out_ready = 1 gives, next cycle, out_valid = 1, imm_in_out = 20'h00FFF, en = 00, has_imm = 1.
REQ-035 The bench SHALL check that instr_in = 32'h123452B7 (lui) gives imm_in_out = 20'h12345, en = 11; and 32'hFE000EE3 (beq x0, x0, -4) gives imm_in_out[11:0] = 12'hFFE, en = 00, imm_shl1 = 1.
REQ-036 The bench SHALL check that with out_ready = 0, accepting words A then B gives in_ready = 0 after B; raising out_ready then outputs A then B on consecutive cycles and in_ready returns to 1.
REQ-037 The bench SHALL check that flush asserted with both entries full and in_valid = 1 gives, next cycle, out_valid = 0, in_ready = 1, and instr_out = 32'h00000013.
REQ-038 The bench SHALL check that instr_in = 32'h0000007F gives illegal = 1, has_imm = 0, imm_in_out = 0, out_valid = 1.
REQ-039 The bench SHALL check that rst asserted while a word is held gives, next cycle, out_valid = 0, in_ready = 1, and all outputs per REQ-031.
